alu_op_sequencer: RTL

- Hardware initiator for the team's 4-bit combinational ALU. On `start` it latches one operand pair and sweeps `alu_sel` through opcodes 0..NUM_OPS-1. Each ALU result is captured, tagged with its opcode and streamed out on a valid/ready port with backpressure.
- It replaces bench-driven opcode sweeps with a synthesizable self-sequencing source, so ALU exercising works on silicon and in system-level sims.

---
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: self-sequencing opcode sweeper for the 4-bit ALU.
// Latches one operand pair on start, steps alu_sel 0..NUM_OPS-1 and
// streams each captured result out on a valid/ready port.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start, in_a, in_b  run request and operands (taken only in IDLE)
//   busy, done         run active / one-cycle completion pulse
//   alu_a/b/sel        registered drive to the combinational ALU
//   alu_x, alu_o       ALU result and flag
//   res_valid/ready    result beat handshake
//   res_sel/x/o        opcode, result and flag of the current beat
//   sig                8-bit result signature (ALU_SEQ_SIG_EN only)
//
// Optional feature macro: ALU_SEQ_SIG_EN
module alu_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_x,
  input  logic             alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_sel,
  output logic [WIDTH-1:0] res_x,
  output logic             res_o
`ifdef ALU_SEQ_SIG_EN
  ,
  output logic [7:0]       sig
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  localparam logic [3:0] SEL_MAX = 4'(NUM_OPS - 1);

  state_t state;
  logic   cap;
  logic   xfer;

  // A new result may be captured whenever the output slot is empty
  // or is being emptied on this same edge.
  assign cap  = (state == RUN) && (!res_valid || res_ready);
  assign xfer = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_sel   <= '0;
      res_x     <= '0;
      res_o     <= 1'b0;
`ifdef ALU_SEQ_SIG_EN
      sig       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_sel <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cap) begin
            res_sel   <= alu_sel;
            res_x     <= alu_x;
            res_o     <= alu_o;
            res_valid <= 1'b1;
            // Park alu_sel on the last opcode so it never overruns.
            if (alu_sel == SEL_MAX) begin
              state <= LAST;
            end else begin
              alu_sel <= alu_sel + 4'd1;
            end
          end
        end
        LAST: begin
          if (xfer) begin
            res_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ALU_SEQ_SIG_EN
      if (state == IDLE && start) begin
        sig <= '0;
      end else if (xfer) begin
        sig <= {sig[6:0], sig[7]} ^ 8'({res_o, res_x});
      end
`endif
    end
  end

endmodule
